fp_mant_addsub_pipe: RTL
========================

Name: fp_mant_addsub_pipe

Overview:
Parametrised, pipelined successor to the FP adder's combinational aligned-mantissa add/subtract stage. It takes exponent-aligned mantissas plus guard/round/sticky (GRS) bits, performs an effective add or subtract, and returns the full-width result with GRS preserved. It also returns the carry, the zero flag, the leading-zero count and the larger exponent, so the normaliser/rounder downstream needs no recompute. It sits between the aligner and the normaliser and carries a valid/ready handshake with back-pressure.

Parameters:
MANT_W, 24, aligned mantissa width including hidden bit
EXP_W, 8, exponent width
GRS_W, 3, guard/round/sticky extension width (>=1)
LZC_W, $clog2(MANT_W+GRS_W+1), leading-zero count width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block accepts operand set this cycle
op_sub  input  1  1: compute A-B; 0: compute A+B
sign_a, sign_b  input  1 each  operand signs
exp_a, exp_b  input  EXP_W each  pre-alignment exponents
mant_a, mant_b  input  MANT_W each  aligned mantissas
grs  input  GRS_W  shifted-out bits of the smaller-exponent operand
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
res_sign  output  1  result sign
res_exp  output  EXP_W  max(exp_a, exp_b)
res_mant  output  MANT_W+GRS_W  magnitude result, GRS in LSBs
carry_out  output  1  magnitude-add overflow (effective add only)
zero  output  1  res_mant == 0
lzc  output  LZC_W  leading zeros of res_mant

Behaviour:
- One clock; reset is synchronous and active-low.
- While rst_n=0 at a clk edge: out_valid=0, res_sign=0, res_exp=0, res_mant=0, carry_out=0, zero=0, lzc=0. All in-flight operations are discarded. in_ready=0 while rst_n=0.
- Pipeline is 2 stages, latency 2 cycles: an operand set accepted at edge T gives out_valid=1 after edge T+2 when there is no stall.
- advance = !(out_valid && !out_ready). in_ready = advance && rst_n. All stage registers hold when advance=0. A transfer happens when valid&&ready.
- Output data is stable while out_valid=1 and out_ready=0. Ordering is preserved. No drop, no duplicate. Bubbles propagate as valid=0.
- Stage 1, operand form:
  - eff_sign_b = sign_b ^ op_sub.
  - ext_x = {mant_x, GRS_W'b0}, except the operand with the strictly smaller exponent takes {mant_x, grs}.
  - If exp_a == exp_b, grs is ignored and treated as 0.
  - Compute the magnitude compare of the full ext_a and ext_b, so GRS participates in tie-break.
  - Register ext_a, ext_b, the compare result, the signs and max exponent.
- Stage 2, arithmetic:
  - Same effective signs: {carry_out, res_mant} = ext_a + ext_b, with res_sign = sign_a.
  - Different effective signs: res_mant = larger - smaller, carry_out = 0, res_sign = sign of the larger operand (sign_a or eff_sign_b).
  - Equal magnitudes on a subtract: res_mant = 0 and res_sign = 0 (+0).
  - zero = (res_mant == 0).
  - lzc counts from the MSB of res_mant; an all-zero result gives lzc = MANT_W+GRS_W.
  - carry_out is excluded from lzc; when carry_out=1, lzc reflects res_mant alone.
- All arithmetic is unsigned on magnitudes. There is no wrap on add: overflow goes only to carry_out.
- Simultaneous in accept and out accept in the same cycle is legal at full throughput (1 op/cycle).

Test Plan:
- (MANT_W=24, GRS_W=3) Add: sign_a=sign_b=0, op_sub=0, exp 0x80/0x80, mant 0x800000/0x800000, grs=3'b111 -> after 2 cycles: carry_out=1, res_mant=0, zero=1, lzc=27, res_exp=0x80, res_sign=0. grs is ignored on equal exponents.
- Subtract with GRS: sign_a=0, sign_b=0, op_sub=1, exp_a=0x81, exp_b=0x80, mant_a=0x800000, mant_b=0x400000, grs=3'b100 -> res_mant=0x1FFFFFC, lzc=2, res_sign=0, carry_out=0, res_exp=0x81.
- Exact cancel: sign_a=1, sign_b=0, op_sub=0, exp 0x90/0x90, mant 0xC00000 both -> res_mant=0, zero=1, lzc=27, res_sign=0.
- GRS tie-break: sign_a=0, sign_b=1, op_sub=0, exp_a=0x7F, exp_b=0x80, mant_a=mant_b=0x400000, grs=3'b010 -> A larger: res_mant=0x000002, lzc=25, res_sign=0.
- Back-pressure: issue 4 back-to-back ops, drop out_ready for 3 cycles after the first out_valid -> in_ready=0 during the stall, output held stable, all 4 results delivered in order with no duplicates.
- Reset mid-flight: 2 ops in flight, rst_n=0 for 1 edge -> out_valid=0 and all outputs 0 after that edge. No stale result ever appears. in_ready=1 the cycle after rst_n returns to 1.

Source files
------------

// File: rtl/fp_mant_addsub_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mant_addsub_pipe_if
//  Brief    : Operand/result handshake bundle for the aligned-mantissa add/sub
//  Revision : 1.0
// ============================================================================
interface fp_mant_addsub_pipe_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int GRS_W  = 3
);
    localparam int LZC_W = $clog2(MANT_W + GRS_W + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic                     op_sub;
    logic                     sign_a;
    logic                     sign_b;
    logic [EXP_W-1:0]         exp_a;
    logic [EXP_W-1:0]         exp_b;
    logic [MANT_W-1:0]        mant_a;
    logic [MANT_W-1:0]        mant_b;
    logic [GRS_W-1:0]         grs;

    logic                     out_valid;
    logic                     out_ready;
    logic                     res_sign;
    logic [EXP_W-1:0]         res_exp;
    logic [MANT_W+GRS_W-1:0]  res_mant;
    logic                     carry_out;
    logic                     zero;
    logic [LZC_W-1:0]         lzc;

    modport master (
        output in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, grs,
        output out_ready,
        input  in_ready,
        input  out_valid, res_sign, res_exp, res_mant, carry_out, zero, lzc
    );

    modport slave (
        input  in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, grs,
        input  out_ready,
        output in_ready,
        output out_valid, res_sign, res_exp, res_mant, carry_out, zero, lzc
    );
endinterface
`default_nettype wire

// File: rtl/fp_mant_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mant_addsub_pipe
//  Brief    : Two-stage aligned-mantissa add/subtract with GRS, carry, zero,
//             leading-zero count and max exponent, valid/ready back-pressure
//  Revision : 1.0
// ============================================================================
module fp_mant_addsub_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int GRS_W  = 3
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    fp_mant_addsub_pipe_if.slave    bus
);
    localparam int TOT_W = MANT_W + GRS_W;
    localparam int LZC_W = $clog2(TOT_W + 1);

    logic advance;
    logic accept;

    // Stage 1: extended operands, magnitude compare, effective signs
    logic              s1_valid_d, s1_valid_q;
    logic [TOT_W-1:0]  ext_a_d,    ext_a_q;
    logic [TOT_W-1:0]  ext_b_d,    ext_b_q;
    logic              a_gt_d,     a_gt_q;
    logic              mag_eq_d,   mag_eq_q;
    logic              sign_a_d,   sign_a_q;
    logic              sign_b_d,   sign_b_q;
    logic [EXP_W-1:0]  exp_d,      exp_q;

    // Stage 2: result registers
    logic              out_valid_d, out_valid_q;
    logic              res_sign_d,  res_sign_q;
    logic [EXP_W-1:0]  res_exp_d,   res_exp_q;
    logic [TOT_W-1:0]  res_mant_d,  res_mant_q;
    logic              carry_d,     carry_q;
    logic              zero_d,      zero_q;
    logic [LZC_W-1:0]  lzc_d,       lzc_q;

    assign advance      = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = advance && rst_n;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        ext_a_d    = ext_a_q;
        ext_b_d    = ext_b_q;
        a_gt_d     = a_gt_q;
        mag_eq_d   = mag_eq_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        exp_d      = exp_q;
        if (advance) begin
            s1_valid_d = accept;
            if (accept) begin
                ext_a_d  = {bus.mant_a, {GRS_W{1'b0}}};
                ext_b_d  = {bus.mant_b, {GRS_W{1'b0}}};
                exp_d    = bus.exp_a;
                // Only the strictly smaller-exponent operand owns the shifted-out bits
                if (bus.exp_a > bus.exp_b) begin
                    ext_b_d[GRS_W-1:0] = bus.grs;
                end else if (bus.exp_b > bus.exp_a) begin
                    ext_a_d[GRS_W-1:0] = bus.grs;
                    exp_d              = bus.exp_b;
                end
                a_gt_d   = (ext_a_d > ext_b_d);
                mag_eq_d = (ext_a_d == ext_b_d);
                sign_a_d = bus.sign_a;
                sign_b_d = bus.sign_b ^ bus.op_sub;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        res_sign_d  = res_sign_q;
        res_exp_d   = res_exp_q;
        res_mant_d  = res_mant_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        lzc_d       = lzc_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                carry_d    = 1'b0;
                res_sign_d = sign_a_q;
                res_exp_d  = exp_q;
                if (sign_a_q == sign_b_q) begin
                    {carry_d, res_mant_d} = {1'b0, ext_a_q} + {1'b0, ext_b_q};
                end else if (a_gt_q) begin
                    res_mant_d = ext_a_q - ext_b_q;
                end else if (mag_eq_q) begin
                    res_mant_d = '0;
                    res_sign_d = 1'b0;
                end else begin
                    res_mant_d = ext_b_q - ext_a_q;
                    res_sign_d = sign_b_q;
                end
                zero_d = (res_mant_d == '0);
                // Highest set bit wins because it is visited last
                lzc_d  = LZC_W'(TOT_W);
                for (int i = 0; i < TOT_W; i++) begin
                    if (res_mant_d[i]) begin
                        lzc_d = LZC_W'(TOT_W - 1 - i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            ext_a_q     <= '0;
            ext_b_q     <= '0;
            a_gt_q      <= 1'b0;
            mag_eq_q    <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            res_sign_q  <= 1'b0;
            res_exp_q   <= '0;
            res_mant_q  <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            lzc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            ext_a_q     <= ext_a_d;
            ext_b_q     <= ext_b_d;
            a_gt_q      <= a_gt_d;
            mag_eq_q    <= mag_eq_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            exp_q       <= exp_d;
            out_valid_q <= out_valid_d;
            res_sign_q  <= res_sign_d;
            res_exp_q   <= res_exp_d;
            res_mant_q  <= res_mant_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            lzc_q       <= lzc_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.res_sign  = res_sign_q;
    assign bus.res_exp   = res_exp_q;
    assign bus.res_mant  = res_mant_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.lzc       = lzc_q;

endmodule
`default_nettype wire
